int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that services the 8 request lines feeding the processor's priority logic. It edge-detects and latches requests, applies a mask register and the global enable (status bit 7), and selects the highest-index eligible source. It presents that source to the core with an `irq`/`ack` request–acknowledge handshake, then tracks in-service until end-of-interrupt (`eoi`). It sits between peripheral request wires and the processor's control/status path.

## Interface
- `N_SRC`, 8: number of request sources; fixed at 8 for this revision.
- `VEC_BASE`, 32'h0000_0100: base address of the vector table.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstN`  in  1  reset; asynchronous assert, active-low.
- `req`  in  8  peripheral request lines; rising edge = new event.
- `status`  in  8  processor status byte; bit 7 = global interrupt enable `int_en`.
- `mask_we`  in  1  write strobe for mask register.
- `mask_wdata`  in  8  new mask value; bit=1 masks that source.
- `ack`  in  1  core acknowledges the presented interrupt.
- `eoi`  in  1  core signals end of interrupt service.
- `irq`  out  1  interrupt request to core.
- `irq_id`  out  3  index of the presented or in-service source.
- `irq_vec`  out  32  handler address, `VEC_BASE + irq_id*4`.
- `in_service`  out  1  high while a handler is active.
- `pending`  out  8  latched pending bits.

## Operation
- **Edge detect:** `req_q` holds last cycle's `req`. Event on bit i when `req[i] & ~req_q[i]`, which sets `pending[i]`. Level-high with no new edge sets nothing.
- **Mask:**
  - `mask_we` loads `mask_wdata` at the next edge.
  - Masked sources still latch pending; they are only excluded from arbitration.
- **Eligible set:** `pending & ~mask`, gated by `status[7]`.
- **Arbitration:** highest set index wins (bit 7 highest). Performed only in IDLE.
- **FSM states:**
  - IDLE → ASSERT: when `status[7]` and the eligible set is non-zero. Latch the winner into `irq_id`/`irq_vec` and set `irq`.
  - ASSERT, `ack`: clear `irq` and `pending[irq_id]`, set `in_service`, go to SERVICE.
  - ASSERT, `status[7]` low without `ack`: drop `irq`, go to IDLE, leave pending untouched.
  - ASSERT, higher-priority edge arrives: no re-arbitration; `irq_id` stays frozen until `ack` or withdrawal.
  - SERVICE, `eoi`: clear `in_service`, go to IDLE. New events keep accumulating in `pending` while in SERVICE.
- **Ignored inputs:**
  - `ack` outside ASSERT.
  - `eoi` outside SERVICE.
  - `ack` and `eoi` asserted together in ASSERT are treated as `ack` only.
- **Set/clear collision:** a new edge on bit i in the same cycle that `ack` clears `pending[i]` leaves `pending[i]=1` (set wins).
- **Width rule:** `irq_vec = VEC_BASE + {27'b0, irq_id, 2'b00}`, 32-bit with no overflow check.

## Timing
- **Reset values (asynchronous, immediate on `rstN` low):**
  - state IDLE, `irq=0`, `irq_id=0`, `irq_vec=VEC_BASE`, `in_service=0`.
  - `pending=8'h00`, `mask=8'hFF` (all masked), `req_q=8'h00`.
  - Reset mid-handshake abandons the interrupt with no `ack` required.
- **All outputs registered;** no combinational path from any input to any output.
- **Request latency:** edge on `req[i]` sampled at edge k gives `pending[i]=1` after k, and `irq=1` after k+1 (2 cycles) if eligible.
- **Acknowledge:** `ack` sampled at edge m gives `irq=0`, `in_service=1` and the pending bit cleared after m.
- **End of interrupt:** `eoi` sampled at edge n puts the FSM in IDLE after n. Earliest next `irq=1` is after n+1.
- **Mask timing:** a mask write at edge k affects arbitration from edge k+1.
- **Release edge:** `req` held high through reset release produces an event in the first cycle after release, because `req_q` resets to 0.

## Structure
- Package `int_ctrl_pkg` holds:
  - state enum `ic_state_t` {IDLE, ASSERT, SERVICE}.
  - `N_SRC`, `ID_W=3`.
  - `ST_INT_EN=7` status bit index.
  - `MASK_RST=8'hFF`.
- One sub-module `int_pri_arb`: combinational 8-bit highest-index-first arbiter producing `id[2:0]` and `valid`. Instantiated once on the eligible set.
- Top `int_ctrl` owns the edge detector, pending/mask registers, FSM and output registers.

## Test plan
- **Basic request:** reset; write `mask=8'h00`, `status=8'hE0`; pulse `req[3]` → `irq=1`, `irq_id=3`, `irq_vec=32'h10C` two cycles later. `ack` → `pending=0`, `in_service=1`. `eoi` → IDLE.
- **Priority:** `req[2]` and `req[6]` rise together → `irq_id=6`. After `ack`/`eoi`, second `irq` with `irq_id=2`, `irq_vec=32'h108`.
- **Masking and enable:**
  - `mask=8'h40` and `req[6]` edge → `pending=8'h40`, no `irq`.
  - Write `mask=8'h00` → `irq_id=6`.
  - Clear `status[7]` during ASSERT → `irq=0`, pending kept.
- **Collision:** new `req[5]` edge in the same cycle as `ack` of id 5 → `pending[5]=1` after the edge. A re-`irq` with id 5 follows `eoi`.
- **Reset mid-operation and held-high request:** assert `rstN=0` while in ASSERT → all outputs at reset values immediately, `mask=8'hFF`. Hold `req[0]=1` across release → `pending=8'h01` one cycle after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the 8-source interrupt controller.
package int_ctrl_pkg;

  localparam int N_SRC     = 8;
  localparam int ID_W      = 3;
  localparam int ST_INT_EN = 7;

  localparam logic [N_SRC-1:0] MASK_RST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } ic_state_t;

  // Handler address: base plus four bytes per source, no overflow handling.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [ID_W-1:0] id);
    return base + {{(32-ID_W-2){1'b0}}, id, 2'b00};
  endfunction

endpackage

// File: rtl/int_pri_arb.sv
// Combinational highest-index-first arbiter over the eligible request set.
module int_pri_arb
  import int_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Priority encode: bit 7 wins over everything below it.
  always_comb begin
    id    = 3'd0;
    valid = 1'b1;
    casez (req)
      8'b1???????: id = 3'd7;
      8'b01??????: id = 3'd6;
      8'b001?????: id = 3'd5;
      8'b0001????: id = 3'd4;
      8'b00001???: id = 3'd3;
      8'b000001??: id = 3'd2;
      8'b0000001?: id = 3'd1;
      8'b00000001: id = 3'd0;
      default: begin
        id    = 3'd0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, global enable,
// irq/ack handshake and in-service tracking until end-of-interrupt.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [N_SRC-1:0] req,
  input  logic [7:0]       status,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [31:0]      irq_vec,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);

  ic_state_t        state_r, state_nxt_s;
  logic [N_SRC-1:0] req_q_r, mask_r, pending_r;
  logic [N_SRC-1:0] edge_s, clr_s, eligible_s, pending_nxt_s;
  logic             irq_r, irq_nxt_s;
  logic [ID_W-1:0]  irq_id_r, irq_id_nxt_s;
  logic [31:0]      irq_vec_r, irq_vec_nxt_s;
  logic             in_service_r, in_service_nxt_s;
  logic [ID_W-1:0]  win_id_s;
  logic             win_valid_s;
  logic             unused_status_s;

  // Only the global-enable bit of the status byte matters here.
  assign unused_status_s = ^status[ST_INT_EN-1:0];

  // Rising-edge events, the eligible set, and the next pending value.
  // A new event on a bit that is being cleared by ack wins (set after clear).
  assign edge_s        = req & ~req_q_r;
  assign eligible_s    = status[ST_INT_EN] ? (pending_r & ~mask_r) : 8'h00;
  assign pending_nxt_s = (pending_r & ~clr_s) | edge_s;

  int_pri_arb u_arb (
    .req   (eligible_s),
    .id    (win_id_s),
    .valid (win_valid_s)
  );

  // Next-state and next-output logic of the request/acknowledge FSM.
  always_comb begin
    state_nxt_s      = state_r;
    irq_nxt_s        = irq_r;
    irq_id_nxt_s     = irq_id_r;
    irq_vec_nxt_s    = irq_vec_r;
    in_service_nxt_s = in_service_r;
    clr_s            = 8'h00;
    case (state_r)
      IDLE: begin
        // Arbitrate only here; the winner is frozen until ack or withdrawal.
        if (status[ST_INT_EN] && win_valid_s) begin
          state_nxt_s   = ASSERT;
          irq_nxt_s     = 1'b1;
          irq_id_nxt_s  = win_id_s;
          irq_vec_nxt_s = vec_addr(VEC_BASE, win_id_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ASSERT: begin
        // ack has priority over a simultaneous eoi or enable drop.
        if (ack) begin
          state_nxt_s      = SERVICE;
          irq_nxt_s        = 1'b0;
          in_service_nxt_s = 1'b1;
          clr_s            = 8'h01 << irq_id_r;
        end else if (!status[ST_INT_EN]) begin
          state_nxt_s = IDLE;
          irq_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ASSERT;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_nxt_s      = IDLE;
          in_service_nxt_s = 1'b0;
        end else begin
          state_nxt_s = SERVICE;
        end
      end
      default: begin
        state_nxt_s      = IDLE;
        irq_nxt_s        = 1'b0;
        in_service_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r      <= IDLE;
      irq_r        <= 1'b0;
      irq_id_r     <= 3'd0;
      irq_vec_r    <= VEC_BASE;
      in_service_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      irq_r        <= irq_nxt_s;
      irq_id_r     <= irq_id_nxt_s;
      irq_vec_r    <= irq_vec_nxt_s;
      in_service_r <= in_service_nxt_s;
    end
  end

  // Request history, pending latch and mask register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      req_q_r   <= 8'h00;
      pending_r <= 8'h00;
      mask_r    <= MASK_RST;
    end else begin
      req_q_r   <= req;
      pending_r <= pending_nxt_s;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  assign irq        = irq_r;
  assign irq_id     = irq_id_r;
  assign irq_vec    = irq_vec_r;
  assign in_service = in_service_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table of per-cycle vectors with a
// scoreboard queue, plus hand-written reset sequences.
module tb_int_ctrl;

  logic        clk;
  logic        rstN;
  logic [7:0]  req;
  logic [7:0]  status;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        ack;
  logic        eoi;
  logic        irq;
  logic [2:0]  irq_id;
  logic [31:0] irq_vec;
  logic        in_service;
  logic [7:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;

  int_ctrl dut (
    .clk        (clk),
    .rstN       (rstN),
    .req        (req),
    .status     (status),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eoi        (eoi),
    .irq        (irq),
    .irq_id     (irq_id),
    .irq_vec    (irq_vec),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  status;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        ack;
    logic        eoi;
    logic        e_irq;
    logic [2:0]  e_id;
    logic        e_is;
    logic [7:0]  e_pend;
  } vec_t;

  typedef struct {
    string       name;
    logic        irq;
    logic [2:0]  id;
    logic [31:0] vec;
    logic        is;
    logic [7:0]  pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic logic [31:0] exp_vec(input logic [2:0] id);
    return 32'h0000_0100 + {27'b0, id, 2'b00};
  endfunction

  task automatic add(input logic [7:0] r, input logic [7:0] s, input logic mw,
                     input logic [7:0] md, input logic a, input logic e,
                     input logic xi, input logic [2:0] xid, input logic xs,
                     input logic [7:0] xp);
    vec_t v;
    v.req = r; v.status = s; v.mask_we = mw; v.mask_wdata = md;
    v.ack = a; v.eoi = e;
    v.e_irq = xi; v.e_id = xid; v.e_is = xs; v.e_pend = xp;
    tbl.push_back(v);
  endtask

  task automatic check_out(input exp_t e);
    n_tests++;
    if (irq !== e.irq || irq_id !== e.id || irq_vec !== e.vec ||
        in_service !== e.is || pending !== e.pend) begin
      n_fail++;
      $display("FAIL %s: got irq=%0b id=%0d vec=%h insvc=%0b pend=%h, want irq=%0b id=%0d vec=%h insvc=%0b pend=%h",
               e.name, irq, irq_id, irq_vec, in_service, pending,
               e.irq, e.id, e.vec, e.is, e.pend);
    end
  endtask

  task automatic expect_now(input string nm, input logic xi, input logic [2:0] xid,
                            input logic [31:0] xv, input logic xs, input logic [7:0] xp);
    exp_t e;
    e.name = nm; e.irq = xi; e.id = xid; e.vec = xv; e.is = xs; e.pend = xp;
    check_out(e);
  endtask

  initial begin
    exp_t e;
    rstN = 1'b1; req = 8'h00; status = 8'h00; mask_we = 1'b0;
    mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;

    // Vector table: inputs held for one cycle, outputs expected after that edge.
    //   req    status mwe wdata  ack eoi  irq id  insvc pend
    // Basic request on source 3.
    add(8'h00, 8'hE0, 1, 8'h00, 0, 0,  0, 3'd0, 0, 8'h00);
    add(8'h08, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd0, 0, 8'h08);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd3, 0, 8'h08);
    add(8'h00, 8'hE0, 0, 8'h00, 1, 0,  0, 3'd3, 1, 8'h00);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 1,  0, 3'd3, 0, 8'h00);
    // Priority: 2 and 6 together, 6 first then 2.
    add(8'h44, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd3, 0, 8'h44);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd6, 0, 8'h44);
    add(8'h00, 8'hE0, 0, 8'h00, 1, 0,  0, 3'd6, 1, 8'h04);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 1,  0, 3'd6, 0, 8'h04);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd2, 0, 8'h04);
    add(8'h00, 8'hE0, 0, 8'h00, 1, 0,  0, 3'd2, 1, 8'h00);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 1,  0, 3'd2, 0, 8'h00);
    // Masking: source 6 masked latches pending but never raises irq.
    add(8'h00, 8'hE0, 1, 8'h40, 0, 0,  0, 3'd2, 0, 8'h00);
    add(8'h40, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd2, 0, 8'h40);
    add(8'h40, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd2, 0, 8'h40);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd2, 0, 8'h40);
    add(8'h00, 8'hE0, 1, 8'h00, 0, 0,  0, 3'd2, 0, 8'h40);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd6, 0, 8'h40);
    // Global enable dropped during ASSERT withdraws irq, keeps pending.
    add(8'h00, 8'h00, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h40);
    add(8'h00, 8'h00, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h40);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd6, 0, 8'h40);
    add(8'h00, 8'hE0, 0, 8'h00, 1, 0,  0, 3'd6, 1, 8'h00);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 1,  0, 3'd6, 0, 8'h00);
    // Collision: new edge on 5 with ack of 5 keeps pending[5].
    add(8'h20, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd6, 0, 8'h20);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd5, 0, 8'h20);
    add(8'h20, 8'hE0, 0, 8'h00, 1, 0,  0, 3'd5, 1, 8'h20);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 1,  0, 3'd5, 0, 8'h20);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd5, 0, 8'h20);
    // ack+eoi together is ack; stray ack/eoi elsewhere ignored.
    add(8'h00, 8'hE0, 0, 8'h00, 1, 1,  0, 3'd5, 1, 8'h00);
    add(8'h00, 8'hE0, 0, 8'h00, 1, 0,  0, 3'd5, 1, 8'h00);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 1,  0, 3'd5, 0, 8'h00);
    add(8'h00, 8'hE0, 0, 8'h00, 1, 1,  0, 3'd5, 0, 8'h00);
    // Higher-priority edge during ASSERT does not re-arbitrate.
    add(8'h02, 8'hE0, 0, 8'h00, 0, 0,  0, 3'd5, 0, 8'h02);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd1, 0, 8'h02);
    add(8'h80, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd1, 0, 8'h82);
    add(8'h00, 8'hE0, 0, 8'h00, 0, 0,  1, 3'd1, 0, 8'h82);

    // Asynchronous reset values, checked with no clock edge in between.
    #2 rstN = 1'b0;
    #1 expect_now("reset_init", 1'b0, 3'd0, 32'h0000_0100, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      req = tbl[i].req; status = tbl[i].status; mask_we = tbl[i].mask_we;
      mask_wdata = tbl[i].mask_wdata; ack = tbl[i].ack; eoi = tbl[i].eoi;
      e.name = $sformatf("vec%0d", i);
      e.irq = tbl[i].e_irq; e.id = tbl[i].e_id; e.vec = exp_vec(tbl[i].e_id);
      e.is = tbl[i].e_is; e.pend = tbl[i].e_pend;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got empty scoreboard, want one entry");
      end else begin
        check_out(sb_q.pop_front());
      end
    end

    // Reset in the middle of ASSERT (id 1 presented), req[0] held through release.
    @(negedge clk);
    req = 8'h00; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    #2 rstN = 1'b0; req = 8'h01;
    #1 expect_now("reset_mid_assert", 1'b0, 3'd0, 32'h0000_0100, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    expect_now("release_edge", 1'b0, 3'd0, 32'h0000_0100, 1'b0, 8'h01);
    @(posedge clk); #1;
    expect_now("mask_rst_ff_a", 1'b0, 3'd0, 32'h0000_0100, 1'b0, 8'h01);
    @(posedge clk); #1;
    expect_now("mask_rst_ff_b", 1'b0, 3'd0, 32'h0000_0100, 1'b0, 8'h01);
    @(negedge clk);
    mask_we = 1'b1; mask_wdata = 8'h00;
    @(posedge clk); #1;
    expect_now("mask_write_edge", 1'b0, 3'd0, 32'h0000_0100, 1'b0, 8'h01);
    @(negedge clk);
    mask_we = 1'b0;
    @(posedge clk); #1;
    expect_now("irq_src0", 1'b1, 3'd0, 32'h0000_0100, 1'b0, 8'h01);

    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
